traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Parametrised N-phase traffic-signal sequencer. It generalises the two-road red/yellow/green controller to NUM_PHASE approaches, with a runtime green duration, speed scaling, a countdown output for the seven-segment/VGA display path, and a flashing-yellow override. It sits between the board clock divider and the lamp, seven-segment and VGA renderers in the trafficlight top level.

## Interface
- NUM_PHASE, 4: number of approaches served round-robin (2..8).
- CNT_W, 6: width of duration and countdown values.
- TICK_DIV, 50000000: CLK cycles per base second tick (power of two ≥ 8 in simulation benches).
- YELLOW_T, 3: yellow duration in ticks (≥1).
- ALLRED_T, 1: all-red clearance in ticks (≥1).
- CLK  in  1  system clock; all logic on rising edge.
- Reset1  in  1  synchronous, active-high reset.
- count_en  in  1  1 = run; 0 = freeze prescaler and countdown (state held).
- speed_select  in  2  tick rate ×1/×2/×4/×8 for 00/01/10/11.
- SW  in  1  1 = flashing-yellow override.
- green_time  in  CNT_W  green duration in ticks, sampled on entry to GREEN; 0 treated as 1.
- red  out  NUM_PHASE  per-approach red lamp.
- yellow  out  NUM_PHASE  per-approach yellow lamp.
- green  out  NUM_PHASE  per-approach green lamp.
- phase  out  3  index of the active approach.
- remaining  out  CNT_W  ticks left in the current state, including the current one.
- tick  out  1  one-cycle pulse on each scaled tick.

## Operation
- States: GREEN, YELLOW, ALLRED, FLASH. Active approach `phase` gets green or yellow. Every other approach is red. ALLRED sets every red.
- Prescaler counts 0..T-1, where T = TICK_DIV >> speed_select. `tick` is high in the cycle the count reaches ≥ T-1; the count then returns to 0.
- A speed_select change is effective immediately. If the count is already ≥ the new T-1, tick fires on the next enabled cycle.
- On tick, if remaining > 1, remaining decrements.
- On tick, if remaining == 1, the block takes the next transition and loads the new state's duration:
  - GREEN→YELLOW loads YELLOW_T.
  - YELLOW→ALLRED loads ALLRED_T.
  - ALLRED→GREEN of (phase+1) mod NUM_PHASE loads max(green_time,1).
- Each state therefore lasts exactly its duration in ticks.
- count_en=0 suppresses tick. The prescaler, remaining and state all hold. SW still acts.
- SW=1 in any state: the next edge enters FLASH. In FLASH:
  - red = 0 and green = 0.
  - yellow = all-ones or all-zeros, toggling on each tick and starting at all-ones.
  - remaining = 0, and phase holds.
- SW falling while in FLASH: the next edge enters ALLRED with remaining = ALLRED_T and phase = NUM_PHASE-1. The sequence then resumes at phase 0 GREEN.
- Reset1 (wins over everything, including SW):
  - state GREEN, phase 0, prescaler 0.
  - remaining = max(green_time,1).
  - green = 0…01, red = 1…10, yellow = 0, tick = 0, flash toggle = 1.
- Lamp outputs are a Moore decode of registered state. Exactly one of red/yellow/green is high per approach outside FLASH.

## Timing
- Lamps, phase and remaining change on the same CLK edge as the state register, with no added latency.
- With count_en=1 and steady speed_select, the first tick after reset arrives T cycles after the cycle Reset1 deasserts.
- A state of duration D spans D·T cycles.
- green_time is sampled only on the edge entering GREEN, or during reset. Later changes do not affect the current green.
- If SW and a tick occur in the same cycle, SW has priority and the tick transition is discarded.
- Reset asserted mid-state aborts the state on that edge. No ALLRED is inserted.

## Configuration
- TRAFFIC_LEFT_TURN_EN
  - Defined: adds a LEFT state between ALLRED and GREEN for each phase, with duration LEFT_T (parameter, default 2, ≥1).
  - During LEFT, output left[NUM_PHASE] is high for the active phase and red stays high for that phase.
  - Reset state becomes LEFT of phase 0 with remaining = LEFT_T.
  - After FLASH exits, ALLRED goes to LEFT of phase 0.
  - Undefined: no LEFT state and no left port.

## Test plan
Setup for all scenarios: NUM_PHASE=3, TICK_DIV=8, YELLOW_T=2, ALLRED_T=1, green_time=3, speed_select=00, count_en=1.
- Reset then release: phase 0 GREEN for 24 cycles, YELLOW for 16, ALLRED for 8, then phase 1 GREEN. remaining reads 3,2,1 during green.
- Cycle through all 3 phases: phase goes 0→1→2→0. Exactly one approach is non-red in every cycle.
- speed_select=11 at the 5th cycle of GREEN with prescaler=4 (≥ T-1=0): tick fires on the next cycle, then every cycle.
- count_en=0 for 20 cycles mid-YELLOW: remaining and prescaler frozen, lamps unchanged. On resume, YELLOW completes its remaining ticks.
- SW=1 mid-GREEN: next edge all lamps off except yellow=111, toggling every 8 cycles. SW=0: next edge ALLRED (red=111) for 8 cycles, then phase 0 GREEN.
- green_time=0 at a GREEN entry: remaining=1 and green lasts 8 cycles. Reset1 with SW=1 held: outputs equal reset values and FLASH is entered on the next edge.

Source files
------------

// File: rtl/traffic_phase_ctrl_if.sv
// Signal bundle between the traffic_phase_ctrl sequencer and its environment.
// Optional feature macro: TRAFFIC_LEFT_TURN_EN adds the per-approach left lamp.
// There is no valid/ready handshake here: inputs are levels sampled on every
// rising CLK edge, and outputs are registered levels plus a one-cycle tick pulse.
interface traffic_phase_ctrl_if #(
   parameter int NUM_PHASE = 4,
   parameter int CNT_W     = 6
);
   logic                 count_en;
   logic [1:0]           speed_select;
   logic                 SW;
   logic [CNT_W-1:0]     green_time;
   logic [NUM_PHASE-1:0] red;
   logic [NUM_PHASE-1:0] yellow;
   logic [NUM_PHASE-1:0] green;
`ifdef TRAFFIC_LEFT_TURN_EN
   logic [NUM_PHASE-1:0] left;
`endif
   logic [2:0]           phase;
   logic [CNT_W-1:0]     remaining;
   logic                 tick;
   logic [2:0]           state_dbg;

   // Environment side: drives the controls, observes lamps and debug state.
   modport master (
      output count_en, speed_select, SW, green_time,
      input  red, yellow, green,
`ifdef TRAFFIC_LEFT_TURN_EN
             left,
`endif
             phase, remaining, tick, state_dbg
   );

   // Sequencer side.
   modport slave (
      input  count_en, speed_select, SW, green_time,
      output red, yellow, green,
`ifdef TRAFFIC_LEFT_TURN_EN
             left,
`endif
             phase, remaining, tick, state_dbg
   );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// N-phase traffic-signal sequencer: round-robin GREEN/YELLOW/ALLRED per
// approach, scaled tick prescaler, countdown output and flashing-yellow override.
// Optional feature macro: TRAFFIC_LEFT_TURN_EN inserts a LEFT state (LEFT_T
// ticks) between ALLRED and GREEN of every phase.
module traffic_phase_ctrl #(
   parameter int NUM_PHASE = 4,
   parameter int CNT_W     = 6,
   parameter int TICK_DIV  = 50000000,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 1
`ifdef TRAFFIC_LEFT_TURN_EN
   ,
   parameter int LEFT_T    = 2
`endif
) (
   input  logic                 CLK,
   input  logic                 Reset1,
   traffic_phase_ctrl_if.slave  bus
);

   localparam int PW = $clog2(TICK_DIV) + 1;

   typedef enum logic [2:0] {
      ST_GREEN  = 3'd0,
      ST_YELLOW = 3'd1,
      ST_ALLRED = 3'd2,
      ST_FLASH  = 3'd3
`ifdef TRAFFIC_LEFT_TURN_EN
      ,
      ST_LEFT   = 3'd4
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       phase_q, phase_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             flash_q, flash_d;

   logic [PW-1:0]    period_m1;
   logic             tick_w;
   logic [CNT_W-1:0] green_len;
   logic [2:0]       phase_next;

   // Tick period tracks speed_select combinationally so a rate change applies at once.
   always_comb begin
      period_m1  = PW'(TICK_DIV >> bus.speed_select) - PW'(1);
      tick_w     = bus.count_en && (presc_q >= period_m1);
      green_len  = (bus.green_time == '0) ? CNT_W'(1) : bus.green_time;
      phase_next = (phase_q == 3'(NUM_PHASE - 1)) ? 3'd0 : phase_q + 3'd1;
   end

   // State register, prescaler, countdown and flash toggle.
   always_ff @(posedge CLK) begin
      state_q <= state_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
      flash_q <= flash_d;
   end

   // Next state: reset, then override entry/exit, then tick-driven sequencing.
   // Entering or leaving FLASH restarts the prescaler so the first flash period
   // and the clearance ALLRED are always a full tick long.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      rem_d   = rem_q;
      presc_d = presc_q;
      flash_d = flash_q;
      if (bus.count_en) begin
         presc_d = tick_w ? '0 : presc_q + PW'(1);
      end
      if (Reset1) begin
         phase_d = 3'd0;
         presc_d = '0;
         flash_d = 1'b1;
`ifdef TRAFFIC_LEFT_TURN_EN
         state_d = ST_LEFT;
         rem_d   = CNT_W'(LEFT_T);
`else
         state_d = ST_GREEN;
         rem_d   = green_len;
`endif
      end else if (bus.SW && (state_q != ST_FLASH)) begin
         state_d = ST_FLASH;
         rem_d   = '0;
         flash_d = 1'b1;
         presc_d = '0;
      end else if (!bus.SW && (state_q == ST_FLASH)) begin
         state_d = ST_ALLRED;
         rem_d   = CNT_W'(ALLRED_T);
         phase_d = 3'(NUM_PHASE - 1);
         presc_d = '0;
      end else if (tick_w) begin
         if (state_q == ST_FLASH) begin
            flash_d = ~flash_q;
         end else if (rem_q > CNT_W'(1)) begin
            rem_d = rem_q - CNT_W'(1);
         end else begin
            case (state_q)
               ST_GREEN: begin
                  state_d = ST_YELLOW;
                  rem_d   = CNT_W'(YELLOW_T);
               end
               ST_YELLOW: begin
                  state_d = ST_ALLRED;
                  rem_d   = CNT_W'(ALLRED_T);
               end
               ST_ALLRED: begin
                  phase_d = phase_next;
`ifdef TRAFFIC_LEFT_TURN_EN
                  state_d = ST_LEFT;
                  rem_d   = CNT_W'(LEFT_T);
`else
                  state_d = ST_GREEN;
                  rem_d   = green_len;
`endif
               end
`ifdef TRAFFIC_LEFT_TURN_EN
               ST_LEFT: begin
                  state_d = ST_GREEN;
                  rem_d   = green_len;
               end
`endif
               default: begin
                  state_d = ST_ALLRED;
                  rem_d   = CNT_W'(ALLRED_T);
               end
            endcase
         end
      end
   end

   // Moore lamp decode from the registered state.
   always_comb begin
      logic [NUM_PHASE-1:0] onehot;
      onehot     = NUM_PHASE'(1) << phase_q;
      bus.red    = '0;
      bus.yellow = '0;
      bus.green  = '0;
`ifdef TRAFFIC_LEFT_TURN_EN
      bus.left   = '0;
`endif
      case (state_q)
         ST_GREEN: begin
            bus.green = onehot;
            bus.red   = ~onehot;
         end
         ST_YELLOW: begin
            bus.yellow = onehot;
            bus.red    = ~onehot;
         end
         ST_FLASH: begin
            bus.yellow = {NUM_PHASE{flash_q}};
         end
`ifdef TRAFFIC_LEFT_TURN_EN
         ST_LEFT: begin
            bus.red  = '1;
            bus.left = onehot;
         end
`endif
         default: begin
            bus.red = '1;
         end
      endcase
      bus.phase     = phase_q;
      bus.remaining = rem_q;
      bus.tick      = tick_w && !Reset1;
      bus.state_dbg = state_q;
   end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: NUM_PHASE=3, TICK_DIV=8, YELLOW_T=2, ALLRED_T=1.
module tb_traffic_phase_ctrl;
   localparam int NP = 3;
   localparam int CW = 6;
   localparam int TD = 8;
   localparam int YT = 2;
   localparam int AT = 1;
   localparam int M_G = 0, M_Y = 1, M_A = 2, M_F = 3;

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   logic Reset1 = 1'b0;
   always #5 CLK = ~CLK;

   traffic_phase_ctrl_if #(.NUM_PHASE(NP), .CNT_W(CW)) bus ();

   traffic_phase_ctrl #(
      .NUM_PHASE(NP), .CNT_W(CW), .TICK_DIV(TD), .YELLOW_T(YT), .ALLRED_T(AT)
   ) dut (
      .CLK(CLK),
      .Reset1(Reset1),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Mode sequence G->Y->A->G(next phase); every mode lasts its length in ticks.
   int m_mode, m_phase, m_rem, m_cnt;
   bit m_flash;
   bit model_on = 1'b0;

   function automatic int green_len(input int gt);
      return (gt == 0) ? 1 : gt;
   endfunction

   function automatic int mode_len(input int mode, input int gt);
      if (mode == M_G) return green_len(gt);
      if (mode == M_Y) return YT;
      return AT;
   endfunction

   always @(posedge CLK) begin
      int t;
      bit tk;
      t  = TD >> bus.speed_select;
      tk = bus.count_en && (m_cnt >= t - 1);
      if (Reset1) begin
         model_on = 1'b1;
         m_mode = M_G; m_phase = 0; m_cnt = 0; m_flash = 1'b1;
         m_rem  = green_len(int'(bus.green_time));
      end else if (model_on) begin
         if (bus.SW && m_mode != M_F) begin
            m_mode = M_F; m_rem = 0; m_flash = 1'b1; m_cnt = 0;
         end else if (!bus.SW && m_mode == M_F) begin
            m_mode = M_A; m_rem = AT; m_phase = NP - 1; m_cnt = 0;
         end else begin
            if (bus.count_en) m_cnt = tk ? 0 : m_cnt + 1;
            if (tk) begin
               if (m_mode == M_F) m_flash = ~m_flash;
               else if (m_rem > 1) m_rem = m_rem - 1;
               else begin
                  m_mode = (m_mode + 1) % 3;
                  if (m_mode == M_G) m_phase = (m_phase + 1) % NP;
                  m_rem = mode_len(m_mode, int'(bus.green_time));
               end
            end
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge CLK) begin
      if (model_on) begin
         logic [2:0] er, ey, eg;
         bit et;
         er = '0; ey = '0; eg = '0;
         for (int i = 0; i < NP; i++) begin
            if (m_mode == M_F) ey[i] = m_flash;
            else if (m_mode == M_A || i != m_phase) er[i] = 1'b1;
            else if (m_mode == M_G) eg[i] = 1'b1;
            else ey[i] = 1'b1;
         end
         et = !Reset1 && bus.count_en && (m_cnt >= (TD >> bus.speed_select) - 1);
         check("model_red", bus.red, er);
         check("model_yellow", bus.yellow, ey);
         check("model_green", bus.green, eg);
         check("model_phase", bus.phase, m_phase);
         check("model_remaining", bus.remaining, m_rem);
         check("model_tick", bus.tick, et);
         if (m_mode != M_F) begin
            for (int i = 0; i < NP; i++)
               check("one_lamp", int'(bus.red[i]) + int'(bus.yellow[i]) + int'(bus.green[i]), 1);
         end
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic [2:0] lamp(input int sel);
      if (sel == 0) return bus.red;
      if (sel == 1) return bus.yellow;
      return bus.green;
   endfunction

   // Caller sits at a negedge; counts consecutive cycles where the lamp equals val.
   task automatic measure(input int sel, input logic [2:0] val, output int n);
      n = 0;
      while (lamp(sel) === val && n < 400) begin
         n++;
         @(negedge CLK);
      end
   endtask

   // Returns at the start of the first cycle after reset release.
   task automatic reset_dut(input bit sw_hold);
      @(posedge CLK); #1;
      Reset1 = 1'b1;
      bus.SW = sw_hold; bus.count_en = 1'b1; bus.speed_select = 2'b00; bus.green_time = 6'd3;
      @(posedge CLK);
      @(negedge CLK);
      check("rst_green", bus.green, 3'b001);
      check("rst_red", bus.red, 3'b110);
      check("rst_yellow", bus.yellow, 3'b000);
      check("rst_tick", bus.tick, 1'b0);
      check("rst_remaining", bus.remaining, 3);
      check("rst_phase", bus.phase, 0);
      @(posedge CLK); #1;
      Reset1 = 1'b0;
   endtask

   task automatic wait_phase(input int p);
      int k;
      k = 0;
      while (bus.phase !== 3'(p) && k < 200) begin
         @(negedge CLK);
         k++;
      end
      check("phase_reached", bus.phase, p);
   endtask

   // ---------------- main stimulus ----------------
   initial begin
      int n, first_tick;
      bus.count_en = 1'b1; bus.speed_select = 2'b00; bus.SW = 1'b0; bus.green_time = 6'd3;

      // Reset release and one full phase sequence.
      reset_dut(1'b0);
      first_tick = -1;
      for (int k = 0; k < 24; k++) begin
         @(negedge CLK);
         if (bus.tick === 1'b1 && first_tick < 0) first_tick = k;
         if (k % 8 == 0) check("rem_green", bus.remaining, 3 - k / 8);
         check("green_on", bus.green, 3'b001);
      end
      check("first_tick_cycle", first_tick, 7);
      @(negedge CLK);
      measure(1, 3'b001, n); check("yellow_cycles", n, 16);
      measure(0, 3'b111, n); check("allred_cycles", n, 8);
      check("next_green", bus.green, 3'b010);
      check("next_phase", bus.phase, 1);
      wait_phase(2);
      wait_phase(0);

      // Speed change to x8 while the prescaler is at 4.
      reset_dut(1'b0);
      repeat (4) @(posedge CLK);
      #1 bus.speed_select = 2'b11;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         check("fast_tick", bus.tick, 1'b1);
         check("fast_rem", bus.remaining, 3 - k);
      end
      @(negedge CLK);
      check("fast_yellow", bus.yellow, 3'b001);
      check("fast_yellow_rem", bus.remaining, 2);
      @(posedge CLK); #1 bus.speed_select = 2'b00;

      // Freeze for 20 cycles four cycles into YELLOW.
      reset_dut(1'b0);
      n = 0;
      while (bus.yellow !== 3'b001 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      check("reach_yellow", bus.yellow, 3'b001);
      repeat (4) @(posedge CLK);
      #1 bus.count_en = 1'b0;
      repeat (20) begin
         @(negedge CLK);
         check("frz_tick", bus.tick, 1'b0);
         check("frz_rem", bus.remaining, 2);
         check("frz_yellow", bus.yellow, 3'b001);
      end
      @(posedge CLK); #1 bus.count_en = 1'b1;
      @(negedge CLK);
      measure(1, 3'b001, n); check("yellow_after_freeze", n, 12);

      // Flash override mid-GREEN, exit, and a zero green_time.
      reset_dut(1'b0);
      repeat (10) @(posedge CLK);
      #1 bus.SW = 1'b1;
      @(negedge CLK);
      check("sw_pre_green", bus.green, 3'b001);
      @(negedge CLK);
      check("flash_yellow", bus.yellow, 3'b111);
      check("flash_red", bus.red, 3'b000);
      check("flash_green", bus.green, 3'b000);
      check("flash_rem", bus.remaining, 0);
      measure(1, 3'b111, n); check("flash_on_cycles", n, 8);
      measure(1, 3'b000, n); check("flash_off_cycles", n, 8);
      @(posedge CLK); #1 bus.SW = 1'b0; bus.green_time = 6'd0;
      @(negedge CLK);
      @(negedge CLK);
      measure(0, 3'b111, n); check("exit_allred_cycles", n, 8);
      check("exit_green", bus.green, 3'b001);
      check("exit_phase", bus.phase, 0);
      check("gt0_rem", bus.remaining, 1);
      bus.green_time = 6'd3;
      measure(2, 3'b001, n); check("gt0_green_cycles", n, 8);

      // Reset with SW held: reset values, then FLASH after release.
      reset_dut(1'b1);
      @(negedge CLK);
      check("rsw_green", bus.green, 3'b001);
      @(negedge CLK);
      check("rsw_flash", bus.yellow, 3'b111);
      check("rsw_red", bus.red, 3'b000);
      @(posedge CLK); #1 bus.SW = 1'b0;

      // Randomized run under the model.
      for (int c = 0; c < 3000; c++) begin
         @(posedge CLK); #1;
         Reset1 = ($urandom_range(0, 599) == 0);
         bus.count_en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 99) == 0) bus.speed_select = 2'($urandom_range(0, 3));
         if (!bus.SW && $urandom_range(0, 399) == 0) bus.SW = 1'b1;
         else if (bus.SW && $urandom_range(0, 39) == 0) bus.SW = 1'b0;
         bus.green_time = 6'($urandom_range(0, 5));
      end
      @(posedge CLK); #1;
      Reset1 = 1'b0; bus.SW = 1'b0;
      repeat (2) @(negedge CLK);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
